// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit_if
// Description : Bus bundle between the fetch unit, instruction memory and
//               decode. perf_* exist only when FETCH_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_data;
    logic                  id_ready;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  halt_req;
    logic                  if_valid;
    logic [31:0]           if_instr;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic [ADDR_WIDTH-1:0] if_pc_plus4;
    logic                  halted;
    logic                  redirect_misaligned;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]           perf_fetched;
    logic [31:0]           perf_stalls;
`endif

    modport master (
        output imem_addr,
        input  imem_data,
        input  id_ready,
        input  redirect_valid,
        input  redirect_target,
        input  halt_req,
        output if_valid,
        output if_instr,
        output if_pc,
        output if_pc_plus4,
        output halted,
`ifdef FETCH_PERF_CNT_EN
        output perf_fetched,
        output perf_stalls,
`endif
        output redirect_misaligned
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output id_ready,
        output redirect_valid,
        output redirect_target,
        output halt_req,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  if_pc_plus4,
        input  halted,
`ifdef FETCH_PERF_CNT_EN
        input  perf_fetched,
        input  perf_stalls,
`endif
        input  redirect_misaligned
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : PC owner and IF/ID register with stall, redirect and halt.
//               Optional perf counters under `define FETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [31:0]           NOP_INSTR  = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    instruction_fetch_unit_if.master bus
);

    localparam logic [1:0] c_ST_BOOT   = 2'b00;
    localparam logic [1:0] c_ST_RUN    = 2'b01;
    localparam logic [1:0] c_ST_HALTED = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP  = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] c_PC_RESET = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_valid;
    logic [31:0]           r_instr;
    logic [ADDR_WIDTH-1:0] r_if_pc;
    logic [ADDR_WIDTH-1:0] r_if_pc_plus4;
    logic                  r_misaligned;

    logic                  w_fire;
    logic                  w_run;
    logic [ADDR_WIDTH-1:0] w_pc_inc;
    logic [ADDR_WIDTH-1:0] w_redirect_pc;

    assign w_fire        = !r_valid || bus.id_ready;
    assign w_run         = (r_state == c_ST_RUN);
    assign w_pc_inc      = r_pc + c_PC_STEP;
    assign w_redirect_pc = {bus.redirect_target[ADDR_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_BOOT;
            r_pc          <= c_PC_RESET;
            r_valid       <= 1'b0;
            r_instr       <= NOP_INSTR;
            r_if_pc       <= '0;
            r_if_pc_plus4 <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            r_misaligned <= bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
            // Redirect overrides every state and drops any pending halt_req.
            if (bus.redirect_valid) begin
                r_pc    <= w_redirect_pc;
                r_valid <= 1'b0;
                r_instr <= NOP_INSTR;
                r_state <= c_ST_RUN;
            end else begin
                case (r_state)
                    c_ST_BOOT: begin
                        r_state <= c_ST_RUN;
                    end
                    c_ST_RUN: begin
                        if (w_fire) begin
                            r_instr       <= bus.imem_data;
                            r_if_pc       <= r_pc;
                            r_if_pc_plus4 <= w_pc_inc;
                            r_valid       <= 1'b1;
                            r_pc          <= w_pc_inc;
                        end
                        if (bus.halt_req) begin
                            r_state <= c_ST_HALTED;
                        end
                    end
                    c_ST_HALTED: begin
                        // Drain the last word but keep its contents visible.
                        if (r_valid && bus.id_ready) begin
                            r_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= c_ST_BOOT;
                    end
                endcase
            end
        end
    end

    assign bus.imem_addr           = r_pc;
    assign bus.if_valid            = r_valid;
    assign bus.if_instr            = r_instr;
    assign bus.if_pc               = r_if_pc;
    assign bus.if_pc_plus4         = r_if_pc_plus4;
    assign bus.halted              = (r_state == c_ST_HALTED);
    assign bus.redirect_misaligned = r_misaligned;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_stalls  <= '0;
        end else if (w_run && !bus.redirect_valid) begin
            if (w_fire && (r_perf_fetched != 32'hFFFF_FFFF)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (!w_fire && (r_perf_stalls != 32'hFFFF_FFFF)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end
        end
    end

    assign bus.perf_fetched = r_perf_fetched;
    assign bus.perf_stalls  = r_perf_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Self-checking bench: directed scenarios plus random traffic
//               against a cycle-level behavioural model of the fetch rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    logic rst2;

    instruction_fetch_unit_if #(.ADDR_WIDTH(32)) bus ();
    instruction_fetch_unit_if #(.ADDR_WIDTH(32)) bus2 ();

    instruction_fetch_unit #(
        .ADDR_WIDTH(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    instruction_fetch_unit #(
        .ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)
    ) dut_wrap (
        .clk(clk), .rst(rst2), .bus(bus2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    assign bus.imem_data  = mem_word(bus.imem_addr);
    assign bus2.imem_data = mem_word(bus2.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the visible fetch state.
    logic [31:0] m_pc, m_if_pc, m_if_pc4, m_instr;
    logic        m_valid, m_booting, m_halted, m_mis;
    logic [31:0] m_fetched, m_stalls;

    task automatic model_reset();
        m_pc = 32'h0; m_if_pc = 32'h0; m_if_pc4 = 32'h0; m_instr = NOP;
        m_valid = 1'b0; m_booting = 1'b1; m_halted = 1'b0; m_mis = 1'b0;
        m_fetched = 32'h0; m_stalls = 32'h0;
    endtask

    task automatic model_update(input logic rv, input logic [31:0] tgt,
                                input logic hq, input logic rdy);
        m_mis = rv && (tgt[1:0] != 2'b00);
        if (rv) begin
            m_pc = tgt & 32'hFFFF_FFFC;
            m_valid = 1'b0; m_instr = NOP; m_booting = 1'b0; m_halted = 1'b0;
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_halted) begin
            if (m_valid && rdy) m_valid = 1'b0;
        end else begin
            if (!m_valid || rdy) begin
                m_instr = mem_word(m_pc); m_if_pc = m_pc; m_if_pc4 = m_pc + 32'd4;
                m_valid = 1'b1; m_pc = m_pc + 32'd4;
                if (m_fetched != 32'hFFFF_FFFF) m_fetched = m_fetched + 32'd1;
            end else if (m_stalls != 32'hFFFF_FFFF) begin
                m_stalls = m_stalls + 32'd1;
            end
            if (hq) m_halted = 1'b1;
        end
    endtask

    function automatic logic [130:0] model_vec();
        return {m_valid, m_instr, m_if_pc, m_if_pc4, m_halted, m_mis, m_pc};
    endfunction

    wire [130:0] act = {bus.if_valid, bus.if_instr, bus.if_pc, bus.if_pc_plus4,
                        bus.halted, bus.redirect_misaligned, bus.imem_addr};

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic rv, input logic [31:0] tgt,
                        input logic hq, input logic rdy);
        bus.redirect_valid = rv; bus.redirect_target = tgt;
        bus.halt_req = hq; bus.id_ready = rdy;
        @(posedge clk);
        model_update(rv, tgt, hq, rdy);
        @(negedge clk);
        bus.redirect_valid = 1'b0; bus.halt_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (act !== {1'b0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL reset_values got=%h want=%h", act, model_vec());
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL boot_cycle got valid=%0b addr=%h want valid=0 addr=0",
                     bus.if_valid, bus.imem_addr);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            n_checks++;
            if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'(4 * i) ||
                bus.if_pc_plus4 !== 32'(4 * i + 4) || bus.if_instr !== mem_word(32'(4 * i))) begin
                n_fail++;
                $display("FAIL stream[%0d] got pc=%h pc4=%h instr=%h want pc=%h instr=%h",
                         i, bus.if_pc, bus.if_pc_plus4, bus.if_instr, 32'(4 * i), mem_word(32'(4 * i)));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b0);
            n_checks++;
            if (bus.if_pc !== 32'h8 || bus.imem_addr !== 32'hC || bus.if_instr !== mem_word(32'h8)
                || act !== model_vec()) begin
                n_fail++;
                $display("FAIL stall_hold[%0d] got pc=%h addr=%h want pc=8 addr=c", i, bus.if_pc, bus.imem_addr);
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (bus.if_pc !== 32'hC || bus.if_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_release got pc=%h want c", bus.if_pc);
        end
    endtask

    task automatic test_redirect();
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h20, 1'b0, 1'b0);
        n_checks++;
        if (bus.if_valid !== 1'b0 || bus.if_instr !== NOP || bus.redirect_misaligned !== 1'b0) begin
            n_fail++;
            $display("FAIL redirect_flush got valid=%0b instr=%h mis=%0b want 0 %h 0",
                     bus.if_valid, bus.if_instr, bus.redirect_misaligned, NOP);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (bus.if_pc !== 32'h20 || bus.if_valid !== 1'b1 || bus.redirect_misaligned !== 1'b0) begin
            n_fail++; $display("FAIL redirect_resume got pc=%h valid=%0b want 20 1", bus.if_pc, bus.if_valid);
        end
    endtask

    task automatic test_misaligned();
        step(1'b1, 32'h23, 1'b0, 1'b1);
        n_checks++;
        if (bus.imem_addr !== 32'h20 || bus.redirect_misaligned !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_pulse got addr=%h mis=%0b want 20 1", bus.imem_addr, bus.redirect_misaligned);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (bus.redirect_misaligned !== 1'b0 || bus.if_pc !== 32'h20) begin
            n_fail++;
            $display("FAIL misaligned_end got mis=%0b pc=%h want 0 20", bus.redirect_misaligned, bus.if_pc);
        end
    endtask

    task automatic test_halt();
        logic [31:0] frozen;
        step(1'b0, 32'h0, 1'b1, 1'b0);
        frozen = bus.imem_addr;
        n_checks++;
        if (bus.halted !== 1'b1 || bus.if_valid !== 1'b1 || act !== model_vec()) begin
            n_fail++; $display("FAIL halt_enter got halted=%0b valid=%0b want 1 1", bus.halted, bus.if_valid);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'h0, 1'b0, 1'b1);
            n_checks++;
            if (bus.halted !== 1'b1 || bus.if_valid !== 1'b0 || bus.imem_addr !== frozen) begin
                n_fail++;
                $display("FAIL halt_drain[%0d] got halted=%0b valid=%0b addr=%h want 1 0 %h",
                         i, bus.halted, bus.if_valid, bus.imem_addr, frozen);
            end
        end
        step(1'b1, 32'h40, 1'b0, 1'b1);
        n_checks++;
        if (bus.halted !== 1'b0 || bus.imem_addr !== 32'h40) begin
            n_fail++; $display("FAIL halt_exit got halted=%0b addr=%h want 0 40", bus.halted, bus.imem_addr);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (bus.if_pc !== 32'h40 || bus.if_valid !== 1'b1) begin
            n_fail++; $display("FAIL halt_resume got pc=%h want 40", bus.if_pc);
        end
    endtask

    task automatic test_simultaneous();
        step(1'b1, 32'h80, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (bus.halted !== 1'b0 || bus.if_pc !== 32'h80 || act !== model_vec()) begin
            n_fail++; $display("FAIL redirect_beats_halt got halted=%0b pc=%h want 0 80", bus.halted, bus.if_pc);
        end
    endtask

    task automatic test_reset_mid_halt();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (bus.halted !== 1'b0 || bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_halt got halted=%0b valid=%0b addr=%h want 0 0 0",
                     bus.halted, bus.if_valid, bus.imem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic rv, hq, rdy;
        logic [31:0] tgt;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            rv  = ($urandom_range(0, 15) == 0);
            tgt = $urandom & 32'h0000_0FFF;
            hq  = ($urandom_range(0, 31) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(rv, tgt, hq, rdy);
            n_checks++;
            if (act !== model_vec()) begin
                n_fail++; $display("FAIL random[%0d] got=%h want=%h", i, act, model_vec());
            end
        end
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (bus.perf_fetched !== m_fetched || bus.perf_stalls !== m_stalls) begin
            n_fail++;
            $display("FAIL perf_counters got f=%0d s=%0d want f=%0d s=%0d",
                     bus.perf_fetched, bus.perf_stalls, m_fetched, m_stalls);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus2.if_valid !== 1'b0 || bus2.imem_addr !== 32'hFFFF_FFF8) begin
            n_fail++;
            $display("FAIL wrap_boot got valid=%0b addr=%h want 0 fffffff8", bus2.if_valid, bus2.imem_addr);
        end
        exp_pc = 32'hFFFF_FFF8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus2.if_valid !== 1'b1 || bus2.if_pc !== exp_pc || bus2.if_pc_plus4 !== exp_pc + 32'd4
                || bus2.if_instr !== mem_word(exp_pc)) begin
                n_fail++;
                $display("FAIL wrap_seq[%0d] got pc=%h pc4=%h want pc=%h", i, bus2.if_pc, bus2.if_pc_plus4, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
        #2;
        rst2 = 1'b1;
        #1;
        n_checks++;
        if (bus2.if_valid !== 1'b0 || bus2.if_pc !== 32'h0 || bus2.imem_addr !== 32'hFFFF_FFF8) begin
            n_fail++;
            $display("FAIL wrap_async_reset got valid=%0b pc=%h addr=%h want 0 0 fffffff8",
                     bus2.if_valid, bus2.if_pc, bus2.imem_addr);
        end
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        bus.id_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = '0; bus.halt_req = 1'b0;
        bus2.id_ready = 1'b1; bus2.redirect_valid = 1'b0; bus2.redirect_target = '0; bus2.halt_req = 1'b0;
        model_reset();
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_halt();
        test_simultaneous();
        test_reset_mid_halt();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
